// File: rtl/alu_rf_pkg.sv
// Shared types and function codes for the register-file/ALU slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_rf_pkg;
    localparam int WORD_SIZE = 16;

    typedef logic [WORD_SIZE-1:0] word_t;
    typedef logic [1:0]           reg_idx_t;
    typedef logic [5:0]           func_t;

    localparam func_t FUNC_ADD = 6'd0;
    localparam func_t FUNC_SUB = 6'd1;
    localparam func_t FUNC_AND = 6'd2;
    localparam func_t FUNC_ORR = 6'd3;
    localparam func_t FUNC_NOT = 6'd4;
    localparam func_t FUNC_TCP = 6'd5;
    localparam func_t FUNC_SHL = 6'd6;
    localparam func_t FUNC_SHR = 6'd7;
endpackage

// File: rtl/alu_rf_if.sv
// Bus bundle for alu_rf: register-file ports plus ALU operands/result.
// Latency: n/a (wires only); overflow exists only with ALU_RF_OVF_EN.
// Backpressure: none, every signal is sampled or driven each cycle.
interface alu_rf_if;
    import alu_rf_pkg::*;

    logic     reg_write;
    reg_idx_t addr1;
    reg_idx_t addr2;
    reg_idx_t addr3;
    word_t    data3;
    word_t    data1;
    word_t    data2;
    word_t    alu_a;
    word_t    alu_b;
    func_t    alu_func;
    word_t    alu_result;
`ifdef ALU_RF_OVF_EN
    logic     overflow;
`endif

    modport master (
        output reg_write, addr1, addr2, addr3, data3, alu_a, alu_b, alu_func,
        input  data1, data2, alu_result
`ifdef ALU_RF_OVF_EN
        , input overflow
`endif
    );

    modport slave (
        input  reg_write, addr1, addr2, addr3, data3, alu_a, alu_b, alu_func,
        output data1, data2, alu_result
`ifdef ALU_RF_OVF_EN
        , output overflow
`endif
    );
endinterface

// File: rtl/alu_rf_alu.sv
// Combinational 16-bit ALU; signed overflow flag only with ALU_RF_OVF_EN.
// Latency: zero cycles.
// Backpressure: none.
module alu_rf_alu
    import alu_rf_pkg::*;
(
    input  word_t alu_a,
    input  word_t alu_b,
    input  func_t alu_func,
    output word_t alu_result
`ifdef ALU_RF_OVF_EN
    , output logic overflow
`endif
);
    always_comb begin
        alu_result = '0;
        unique case (alu_func)
            FUNC_ADD: alu_result = alu_a + alu_b;
            FUNC_SUB: alu_result = alu_a - alu_b;
            FUNC_AND: alu_result = alu_a & alu_b;
            FUNC_ORR: alu_result = alu_a | alu_b;
            FUNC_NOT: alu_result = ~alu_a;
            FUNC_TCP: alu_result = ~alu_a + 16'd1;
            FUNC_SHL: alu_result = {alu_a[WORD_SIZE-2:0], 1'b0};
            FUNC_SHR: alu_result = {alu_a[WORD_SIZE-1], alu_a[WORD_SIZE-1:1]};
            default:  alu_result = '0;
        endcase
    end

`ifdef ALU_RF_OVF_EN
    // Overflow shows up as a result sign that disagrees with what the operand signs allow.
    always_comb begin
        overflow = 1'b0;
        if (alu_func == FUNC_ADD)
            overflow = (alu_a[WORD_SIZE-1] == alu_b[WORD_SIZE-1]) &&
                       (alu_result[WORD_SIZE-1] != alu_a[WORD_SIZE-1]);
        else if (alu_func == FUNC_SUB)
            overflow = (alu_a[WORD_SIZE-1] != alu_b[WORD_SIZE-1]) &&
                       (alu_result[WORD_SIZE-1] != alu_a[WORD_SIZE-1]);
    end
`endif
endmodule

// File: rtl/alu_rf.sv
// Four-entry register file with two combinational read ports, plus ALU (ALU_RF_OVF_EN adds overflow).
// Latency: reads and ALU zero cycles; writes visible after the next rising edge, no bypass.
// Backpressure: none; reset (sync, active-low) beats a simultaneous write.
module alu_rf #(
    parameter int WORD_SIZE = alu_rf_pkg::WORD_SIZE
) (
    input  logic     clk,
    input  logic     reset_n,
    alu_rf_if.slave  bus
);
    import alu_rf_pkg::*;

    logic [WORD_SIZE-1:0] regs_q [4];
    logic [WORD_SIZE-1:0] regs_d [4];

    always_comb begin
        for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];
        if (bus.reg_write) regs_d[bus.addr3] = bus.data3;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
        end
    end

    // Reads come from the flops, so a same-cycle write is not forwarded.
    assign bus.data1 = regs_q[bus.addr1];
    assign bus.data2 = regs_q[bus.addr2];

    alu_rf_alu u_alu (
        .alu_a      (bus.alu_a),
        .alu_b      (bus.alu_b),
        .alu_func   (bus.alu_func),
        .alu_result (bus.alu_result)
`ifdef ALU_RF_OVF_EN
        , .overflow (bus.overflow)
`endif
    );
endmodule

// File: tb/tb_alu_rf.sv
// Self-checking bench for alu_rf: directed ALU table, register-file sequences, randomized run.
// Works with or without ALU_RF_OVF_EN.
module tb_alu_rf;
    import alu_rf_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_rf_if bus ();

    alu_rf #(.WORD_SIZE(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [15:0] model_rf [4];

    typedef struct {
        string       name;
        logic [5:0]  func;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_res;
        logic        exp_ovf;
    } alu_vec_t;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Reference ALU built from integer arithmetic rather than bit slicing.
    function automatic logic [15:0] ref_alu(input logic [5:0] f, input logic [15:0] a, input logic [15:0] b);
        int ua, ub, sa, r;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        case (f)
            6'd0: r = (ua + ub) % 65536;
            6'd1: r = (ua - ub + 65536) % 65536;
            6'd2: r = int'(a & b);
            6'd3: r = int'(a | b);
            6'd4: r = 65535 - ua;
            6'd5: r = (65536 - ua) % 65536;
            6'd6: r = (ua * 2) % 65536;
            6'd7: begin
                r = (sa >= 0) ? sa / 2 : -((-sa + 1) / 2);
                if (r < 0) r = r + 65536;
            end
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    function automatic logic ref_ovf(input logic [5:0] f, input logic [15:0] a, input logic [15:0] b);
        int sa, sb, t;
        sa = (int'(a) >= 32768) ? int'(a) - 65536 : int'(a);
        sb = (int'(b) >= 32768) ? int'(b) - 65536 : int'(b);
        if (f == 6'd0)      t = sa + sb;
        else if (f == 6'd1) t = sa - sb;
        else                t = 0;
        return (t > 32767) || (t < -32768);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_regs(input string name);
        for (int i = 0; i < 4; i++) begin
            bus.addr1 = 2'(i);
            bus.addr2 = 2'(3 - i);
            #1;
            check16($sformatf("%s_d1_r%0d", name, i), bus.data1, model_rf[i]);
            check16($sformatf("%s_d2_r%0d", name, 3 - i), bus.data2, model_rf[3 - i]);
        end
    endtask

    alu_vec_t vecs [10];

    initial begin
        vecs[0] = '{"add_ovf", FUNC_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b1};
        vecs[1] = '{"sub_neg", FUNC_SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0};
        vecs[2] = '{"tcp_one", FUNC_TCP, 16'h0001, 16'h0000, 16'hFFFF, 1'b0};
        vecs[3] = '{"and",     FUNC_AND, 16'h8002, 16'h00FF, 16'h0002, 1'b0};
        vecs[4] = '{"orr",     FUNC_ORR, 16'h8002, 16'h00FF, 16'h80FF, 1'b0};
        vecs[5] = '{"not",     FUNC_NOT, 16'h8002, 16'h00FF, 16'h7FFD, 1'b0};
        vecs[6] = '{"shl",     FUNC_SHL, 16'h8002, 16'h00FF, 16'h0004, 1'b0};
        vecs[7] = '{"shr",     FUNC_SHR, 16'h8002, 16'h00FF, 16'hC001, 1'b0};
        vecs[8] = '{"bad_1c",  6'h1C,    16'h8002, 16'h00FF, 16'h0000, 1'b0};
        vecs[9] = '{"sub_ovf", FUNC_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b1};

        reset_n       = 1'b1;
        bus.reg_write = 1'b0;
        bus.addr1     = '0;
        bus.addr2     = '0;
        bus.addr3     = '0;
        bus.data3     = '0;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_func  = '0;
        #2;

        // Reset with a competing write: the write must be dropped.
        reset_n       = 1'b0;
        bus.reg_write = 1'b1;
        bus.addr3     = 2'd1;
        bus.data3     = 16'hFFFF;
        tick();
        reset_n       = 1'b1;
        bus.reg_write = 1'b0;
        for (int i = 0; i < 4; i++) model_rf[i] = 16'h0000;
        check_all_regs("reset");

        // Write r2 and observe no bypass, then dual-read the same address.
        bus.reg_write = 1'b1;
        bus.addr3     = 2'd2;
        bus.data3     = 16'h1234;
        bus.addr1     = 2'd2;
        #1;
        check16("wr_before_edge", bus.data1, 16'h0000);
        tick();
        bus.reg_write = 1'b0;
        model_rf[2]   = 16'h1234;
        #1;
        check16("wr_after_edge", bus.data1, 16'h1234);
        bus.addr2 = 2'd2;
        #1;
        check16("dual_read_d1", bus.data1, 16'h1234);
        check16("dual_read_d2", bus.data2, 16'h1234);

        // Fill all four registers, then a cycle with reg_write low.
        for (int i = 0; i < 4; i++) begin
            bus.reg_write = 1'b1;
            bus.addr3     = 2'(i);
            bus.data3     = 16'h000A + 16'(i);
            tick();
            model_rf[i]   = 16'h000A + 16'(i);
        end
        bus.reg_write = 1'b0;
        bus.addr3     = 2'd1;
        bus.data3     = 16'hBEEF;
        tick();
        check_all_regs("isolate");

        // A reset pulse that ends before the next edge must not clear anything.
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        tick();
        check_all_regs("glitch_rst");

        // Directed ALU vectors.
        for (int i = 0; i < 10; i++) begin
            bus.alu_func = vecs[i].func;
            bus.alu_a    = vecs[i].a;
            bus.alu_b    = vecs[i].b;
            #1;
            check16(vecs[i].name, bus.alu_result, vecs[i].exp_res);
`ifdef ALU_RF_OVF_EN
            check1({vecs[i].name, "_ovf"}, bus.overflow, vecs[i].exp_ovf);
`endif
        end

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            logic        rw, rst;
            logic [5:0]  f;
            int          sel;
            rst = ($urandom_range(0, 49) == 0);
            rw  = $urandom_range(0, 1) == 1;
            sel = $urandom_range(0, 9);
            f   = (sel < 8) ? 6'(sel) : 6'($urandom_range(8, 63));
            reset_n       = ~rst;
            bus.reg_write = rw;
            bus.addr1     = 2'($urandom_range(0, 3));
            bus.addr2     = 2'($urandom_range(0, 3));
            bus.addr3     = 2'($urandom_range(0, 3));
            bus.data3     = 16'($urandom);
            bus.alu_a     = 16'($urandom);
            bus.alu_b     = 16'($urandom);
            bus.alu_func  = f;
            #1;
            check16($sformatf("rnd%0d_d1", n), bus.data1, model_rf[bus.addr1]);
            check16($sformatf("rnd%0d_d2", n), bus.data2, model_rf[bus.addr2]);
            check16($sformatf("rnd%0d_alu", n), bus.alu_result, ref_alu(f, bus.alu_a, bus.alu_b));
`ifdef ALU_RF_OVF_EN
            check1($sformatf("rnd%0d_ovf", n), bus.overflow, ref_ovf(f, bus.alu_a, bus.alu_b));
`endif
            tick();
            if (rst) begin
                for (int i = 0; i < 4; i++) model_rf[i] = 16'h0000;
            end else if (rw) begin
                model_rf[bus.addr3] = bus.data3;
            end
        end
        reset_n       = 1'b1;
        bus.reg_write = 1'b0;
        check_all_regs("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
